// File: rtl/clk_div_ctrl.sv
// Run/stop and ratio controller for the clock divider: produces a registered,
// glitch-free divided clock and swaps ratios only at period boundaries.
module clk_div_ctrl #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned DIV_RESET = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] div_cur
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned MIN_DIV = 2;

    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [CNT_W-1:0] div_cur_q,   div_cur_d;
    logic [CNT_W-1:0] pend_div_q,  pend_div_d;
    logic             pend_q,      pend_d;
    logic             clk_out_q,   clk_out_d;
    logic             tick_q,      tick_d;
    logic             busy_q,      busy_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             cfg_err_q,   cfg_err_d;

    logic [CNT_W-1:0] hi_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             at_bound_c;
    logic             xfer_c;

    // High phase is ceil(div/2) cycles, low phase floor(div/2).
    assign hi_c       = div_cur_q - (div_cur_q >> 1);
    assign cnt_inc_c  = cnt_q + CNT_W'(1);
    assign at_bound_c = (cnt_q == (div_cur_q - CNT_W'(1)));
    assign xfer_c     = cfg_valid & cfg_ready_q;

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_cur_q   <= CNT_W'(DIV_RESET);
            pend_div_q  <= '0;
            pend_q      <= 1'b0;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_cur_q   <= div_cur_d;
            pend_div_q  <= pend_div_d;
            pend_q      <= pend_d;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
            busy_q      <= busy_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Next-state, handshake and phase logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        pend_div_d = pend_div_q;
        pend_d     = pend_q;
        clk_out_d  = 1'b0;
        tick_d     = 1'b0;
        cfg_err_d  = 1'b0;

        // cfg_ready high implies no pending ratio, so capture never races the apply below.
        if (xfer_c) begin
            if (cfg_div < CNT_W'(MIN_DIV)) begin
                cfg_err_d = 1'b1;
            end else begin
                pend_div_d = cfg_div;
                pend_d     = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pend_q) begin
                    div_cur_d = pend_div_q;
                    pend_d    = 1'b0;
                end
                if (run) begin
                    state_d   = RUN;
                    clk_out_d = 1'b1;
                    tick_d    = 1'b1;
                end
            end
            RUN: begin
                if (at_bound_c) begin
                    cnt_d = '0;
                    if (pend_q) begin
                        div_cur_d = pend_div_q;
                        pend_d    = 1'b0;
                    end
                    if (run) begin
                        clk_out_d = 1'b1;
                        tick_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d     = cnt_inc_c;
                    clk_out_d = (cnt_inc_c < hi_c);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        cfg_ready_d = ~pend_d;
        busy_d      = (state_d == RUN);
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign busy      = busy_q;
    assign div_cur   = div_cur_q;

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Run/stop and ratio controller for the team's clock divider.
- Generates a registered, glitch-free divided clock from clk_in.
- Accepts new divide ratios over a valid/ready configuration handshake.
- Applies ratio changes only at period boundaries, so no runt or stretched pulse reaches downstream logic.
- Sits between the system control registers and every block clocked or enabled by the divided clock.

Parameters:
- CNT_W, 8: width of divide ratio and internal period counter.
- DIV_RESET, 2: divide ratio loaded at reset. Must be >= 2 and < 2^CNT_W.

Ports:
- clk_in  input  1  source clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- run  input  1  level request: 1 = generate clk_out, 0 = stop at the next period boundary.
- cfg_valid  input  1  new ratio offered on cfg_div.
- cfg_div  input  CNT_W  requested divide ratio.
- cfg_ready  output  1  controller can accept a ratio.
- cfg_err  output  1  one-cycle pulse: offered ratio rejected.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse, coincident with each clk_out rising edge.
- busy  output  1  state is RUN.
- div_cur  output  CNT_W  ratio currently in effect.

Behaviour:
Reset (rst=0, asynchronous) forces:
- clk_out=0, tick=0, cfg_err=0, busy=0
- cfg_ready=1
- div_cur=DIV_RESET
- internal cnt=0, pend=0, state IDLE

Phase split:
- hi = div_cur - floor(div_cur/2), i.e. high phase is ceil(div/2) cycles, low phase is floor(div/2).
- Examples: div=2 gives 1 high / 1 low; div=5 gives 3 high / 2 low.

State IDLE:
- clk_out=0, cnt=0.
- If pend=1: div_cur<=pend_div and pend<=0 on the next edge.
- If run=1 is sampled: state<=RUN, cnt<=0, clk_out<=1, tick<=1 on that same edge (1-cycle latency from run).
- If pend and run occur together: the new ratio governs the first period.

State RUN, not at a boundary (cnt != div_cur-1):
- cnt<=cnt+1
- clk_out<=(cnt+1 < hi)
- tick<=0

State RUN, at a boundary (cnt == div_cur-1):
- If pend=1: div_cur<=pend_div and pend<=0. Applies whether continuing or stopping.
- cnt<=0.
- If run=1: clk_out<=1, tick<=1, and the next period uses the updated div_cur.
- If run=0: state<=IDLE, clk_out stays 0.

Run/stop rules:
- run dropping mid-period never truncates a period.
- run re-asserted before the boundary means no interruption.

Configuration handshake:
- Transfer occurs when cfg_valid & cfg_ready.
- If cfg_div < 2: cfg_err=1 for the next cycle, data discarded, cfg_ready stays 1.
- Otherwise: pend_div<=cfg_div, pend<=1, cfg_ready<=0.
- cfg_ready returns to 1 on the cycle after pend clears.
- A transfer on the same edge as a boundary does not affect that boundary. The ratio applies at the following boundary, or in the next cycle if in IDLE.

Other outputs and constraints:
- busy = (state==RUN), registered.
- clk_out is never combinational; it is always driven from a flop.

Test Plan:
1. Hold rst=0 then release with run=0 for 10 cycles. Expect clk_out=0, busy=0, cfg_ready=1, div_cur=2.
2. run=1 with default div=2. clk_out rises on the first sampled edge, pattern 1,0,1,0. tick high on each rising cycle, busy=1.
3. In IDLE, send cfg_div=5. Expect cfg_ready low exactly 1 cycle, div_cur=5. Then run=1 gives 3 cycles high, 2 low, tick every 5 cycles.
4. Running at div=4, send cfg_div=6 at cnt=1. Current period stays 4 cycles; the next is 3 high / 3 low. cfg_ready reasserts the cycle after the boundary.
5. Send cfg_div=1, then cfg_div=0. Each gives a 1-cycle cfg_err pulse; div_cur and clk_out are unchanged and cfg_ready stays 1.
6. At div=6, drop run at cnt=1.
   - Expect the period to complete: 3 high, 3 low.
   - busy falls at the boundary, with no further tick.
   - Separately, assert rst mid-high-phase: clk_out=0 immediately, without waiting for a clk_in edge.
